key_search_ctrl: RTL and testbench

KEY_SEARCH_CTRL -- requirements
Module: key_search_ctrl

---
 rtl/key_search_ctrl.sv | 126 ++++++++++++
 tb/tb_key_search_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/key_search_ctrl.sv
// Sequential key search over an external synchronous-read table: first-match early stop by default,
// or a full scan with a match counter when KEY_SEARCH_COUNT_EN is defined.
module key_search_ctrl #(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        key,
  input  logic [ADDR_W:0]   len,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [7:0]        mem_data,
  output logic              busy,
  output logic              done,
  output logic              found,
  output logic [ADDR_W-1:0] match_idx,
`ifdef KEY_SEARCH_COUNT_EN
  output logic [ADDR_W:0]   match_cnt,
`endif
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, FIN} state_t;

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  state_t            state, state_nx;
  logic [7:0]        key_q;
  logic [ADDR_W:0]   last_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] cmp_addr_q;
  logic              rd_q;
  logic              found_q;
  logic [ADDR_W-1:0] idx_q;
  logic [ADDR_W:0]   len_sat;
  logic              hit;
  logic              early_stop;
  logic              accept;

  assign len_sat = (len > DEPTH) ? DEPTH : len;
  assign accept  = (state == IDLE) && start;

  // rd_q marks the cycle in which mem_data belongs to the address held in cmp_addr_q.
  assign hit = rd_q && (mem_data == key_q);

`ifdef KEY_SEARCH_COUNT_EN
  logic [ADDR_W:0] cnt_q;
  assign early_stop = 1'b0;
  assign match_cnt  = cnt_q;
`else
  assign early_stop = hit;
`endif

  always_comb begin
    state_nx = state;
    mem_rd   = 1'b0;
    mem_addr = '0;
    busy     = (state != IDLE);
    done     = (state == FIN);
    case (state)
      IDLE: begin
        if (start) state_nx = (len == '0) ? FIN : SCAN;
      end
      SCAN: begin
        mem_addr = addr_q;
        // A match seen this cycle suppresses the read that would otherwise follow it.
        if (early_stop) begin
          state_nx = FIN;
        end else begin
          mem_rd = 1'b1;
          if ({1'b0, addr_q} == last_q) state_nx = DRAIN;
        end
      end
      DRAIN:   state_nx = FIN;
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      key_q      <= '0;
      last_q     <= '0;
      addr_q     <= '0;
      cmp_addr_q <= '0;
      rd_q       <= 1'b0;
      found_q    <= 1'b0;
      idx_q      <= '0;
`ifdef KEY_SEARCH_COUNT_EN
      cnt_q      <= '0;
`endif
    end else begin
      state      <= state_nx;
      rd_q       <= mem_rd;
      cmp_addr_q <= mem_addr;
      if (accept) begin
        key_q   <= key;
        last_q  <= len_sat - (ADDR_W+1)'(1);
        addr_q  <= '0;
        found_q <= 1'b0;
        idx_q   <= '0;
`ifdef KEY_SEARCH_COUNT_EN
        cnt_q   <= '0;
`endif
      end else begin
        if (mem_rd) addr_q <= addr_q + ADDR_W'(1);
        if (hit) begin
          if (!found_q) begin
            found_q <= 1'b1;
            idx_q   <= cmp_addr_q;
          end
`ifdef KEY_SEARCH_COUNT_EN
          cnt_q <= cnt_q + (ADDR_W+1)'(1);
`endif
        end
      end
    end
  end

  assign found     = found_q;
  assign match_idx = idx_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_key_search_ctrl.sv
// Directed bench for key_search_ctrl with a synchronous-read table model; builds with or without
// KEY_SEARCH_COUNT_EN and selects the expected values to match.
module tb_key_search_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] key;
  logic [4:0] len;
  logic [3:0] mem_addr;
  logic       mem_rd;
  logic [7:0] mem_data;
  logic       busy;
  logic       done;
  logic       found;
  logic [3:0] match_idx;
  logic [1:0] dbg_state;
`ifdef KEY_SEARCH_COUNT_EN
  logic [4:0] match_cnt;
`endif

  logic [7:0] mem [16];

  int n_tests = 0;
  int n_fail  = 0;

  int rd_n, max_addr, seq_err, done_cyc, done_n;

  key_search_ctrl #(.ADDR_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .key       (key),
    .len       (len),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .mem_data  (mem_data),
    .busy      (busy),
    .done      (done),
    .found     (found),
    .match_idx (match_idx),
`ifdef KEY_SEARCH_COUNT_EN
    .match_cnt (match_cnt),
`endif
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // table model: data returned the cycle after the read strobe
  always @(posedge clk) begin
    if (mem_rd) mem_data <= mem[mem_addr];
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic load_ramp();
    for (int i = 0; i < 16; i++) mem[i] = 8'h10 + 8'(i);
  endtask

  task automatic load_sparse();
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    mem[2] = 8'h7E;
    mem[5] = 8'h7E;
    mem[9] = 8'h7E;
  endtask

  // Drive one search; cycle c is the period following start edge c-1.
  task automatic run_search(input logic [7:0] k, input logic [4:0] l, input int restart_at);
    @(negedge clk);
    key = k; len = l; start = 1'b1;
    @(posedge clk);
    rd_n = 0; max_addr = 0; seq_err = 0; done_cyc = -1; done_n = 0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      start = (c == restart_at);
      if (start) begin key = 8'h00; len = 5'd1; end
      if (mem_rd) begin
        rd_n++;
        if (int'(mem_addr) > max_addr) max_addr = int'(mem_addr);
        if (int'(mem_addr) != c - 1) seq_err++;
      end
      if (done) begin
        done_n++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (done_cyc >= 0 && c >= done_cyc + 3) break;
    end
    start = 1'b0;
  endtask

  task automatic expect_search(input string tag, input int e_done, input int e_rd, input int e_max,
                               input int e_found, input int e_idx);
    check({tag, ".done_cycle"}, done_cyc, e_done);
    check({tag, ".done_pulses"}, done_n, 1);
    check({tag, ".reads"}, rd_n, e_rd);
    if (e_rd > 0) check({tag, ".max_addr"}, max_addr, e_max);
    check({tag, ".addr_seq"}, seq_err, 0);
    check({tag, ".found"}, int'(found), e_found);
    check({tag, ".match_idx"}, int'(match_idx), e_idx);
    check({tag, ".busy_after"}, int'(busy), 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; key = 8'h00; len = 5'd0; mem_data = 8'h00;
    load_ramp();
    #1;
    check("reset.mem_rd", int'(mem_rd), 0);
    check("reset.mem_addr", int'(mem_addr), 0);
    check("reset.busy", int'(busy), 0);
    check("reset.done", int'(done), 0);
    check("reset.found", int'(found), 0);
    check("reset.match_idx", int'(match_idx), 0);
`ifdef KEY_SEARCH_COUNT_EN
    check("reset.match_cnt", int'(match_cnt), 0);
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    run_search(8'h13, 5'd16, 0);
`ifdef KEY_SEARCH_COUNT_EN
    expect_search("hit3", 18, 16, 15, 1, 3);
    check("hit3.match_cnt", int'(match_cnt), 1);
`else
    expect_search("hit3", 6, 4, 3, 1, 3);
`endif

    run_search(8'hAA, 5'd16, 0);
    expect_search("miss16", 18, 16, 15, 0, 0);
`ifdef KEY_SEARCH_COUNT_EN
    check("miss16.match_cnt", int'(match_cnt), 0);
`endif

    run_search(8'h13, 5'd0, 0);
    expect_search("len0", 1, 0, 0, 0, 0);

    run_search(8'hAA, 5'd31, 0);
    expect_search("len_sat", 18, 16, 15, 0, 0);

    run_search(8'h10, 5'd1, 0);
    expect_search("len1_hit", 3, 1, 0, 1, 0);

    run_search(8'h1F, 5'd4, 0);
    expect_search("len4_miss", 6, 4, 3, 0, 0);

    run_search(8'h13, 5'd16, 3);
`ifdef KEY_SEARCH_COUNT_EN
    expect_search("restart_ign", 18, 16, 15, 1, 3);
`else
    expect_search("restart_ign", 6, 4, 3, 1, 3);
`endif

    load_sparse();
    run_search(8'h7E, 5'd16, 0);
`ifdef KEY_SEARCH_COUNT_EN
    expect_search("multi", 18, 16, 15, 1, 2);
    check("multi.match_cnt", int'(match_cnt), 3);
`else
    expect_search("multi", 5, 3, 2, 1, 2);
`endif

    // reset in cycle 4 of a miss search
    load_ramp();
    @(negedge clk);
    key = 8'hAA; len = 5'd16; start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    #1;
    check("midrst.mem_rd", int'(mem_rd), 0);
    check("midrst.mem_addr", int'(mem_addr), 0);
    check("midrst.busy", int'(busy), 0);
    check("midrst.done", int'(done), 0);
    check("midrst.found", int'(found), 0);
    done_n = 0; rd_n = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (done) done_n++;
      if (mem_rd) rd_n++;
    end
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done) done_n++;
      if (mem_rd) rd_n++;
    end
    check("midrst.no_done", done_n, 0);
    check("midrst.no_reads", rd_n, 0);

    run_search(8'h15, 5'd16, 0);
`ifdef KEY_SEARCH_COUNT_EN
    expect_search("after_rst", 18, 16, 15, 1, 5);
    check("after_rst.match_cnt", int'(match_cnt), 1);
`else
    expect_search("after_rst", 8, 6, 5, 1, 5);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
